// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: funct3 codes,
// FSM state encoding, byte-lane mask and load-extract helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic logic [3:0] be_mask(
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic [3:0] m;
        case (funct3)
            F3_B, F3_BU: m = 4'b0001 << off;
            F3_H, F3_HU: m = 4'b0011 << off;
            F3_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [2:0]  funct3,
        input logic [1:0]  off
    );
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {off, 3'b000};
        case (funct3)
            F3_B:    r = {{24{s[7]}}, s[7:0]};
            F3_BU:   r = {24'h0, s[7:0]};
            F3_H:    r = {{16{s[15]}}, s[15:0]};
            F3_HU:   r = {16'h0, s[15:0]};
            F3_W:    r = s;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ctrl_be_ram.sv
// DEPTH x 32 storage with per-byte write enables and a registered read.
// Ports: clk; addr (word index); we (lane enables); wdata; q (read data).
module dmem_ctrl_be_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);
    logic [31:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed RV32I data memory: sized loads/stores, error flags,
// optional post-reset zero-fill and an RD_LAT-deep response pipeline.
// Ports: clk, rst_n; req_* valid/ready request; rsp_* response.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int AW           = 10,
    parameter int RD_LAT       = 1,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW+1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err
);
    localparam int DEPTH = 1 << AW;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic          acc;
    logic          ill;
    logic          mis;
    logic          err;
    logic [1:0]    off;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_q;

    logic          m_v;
    logic          m_ld;
    logic          m_err;
    logic [2:0]    m_f3;
    logic [1:0]    m_off;

    logic [RD_LAT-1:0] v_in;
    logic [RD_LAT-1:0] pv;
    logic [32:0]       p_in [RD_LAT];
    logic [32:0]       pd   [RD_LAT];

    assign req_ready = (state == READY) && rst_n;
    assign acc       = req_valid && req_ready;
    assign off       = req_addr[1:0];
    assign err       = ill || mis;

    always_comb begin
        case (req_funct3)
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_BU, F3_HU:     ill = req_we;
            default:          ill = 1'b1;
        endcase
        case (req_funct3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
    end

    // The zero-fill sequence owns the RAM port while clearing.
    always_comb begin
        if (state == CLEAR) begin
            ram_addr  = clr_cnt;
            ram_we    = {4{rst_n}};
            ram_wdata = 32'h0;
        end else begin
            ram_addr  = req_addr[AW+1:2];
            ram_we    = 4'b0000;
            if (acc && req_we && !err) begin
                ram_we = be_mask(req_funct3, off);
            end
            ram_wdata = req_wdata << {off, 3'b000};
        end
    end

    dmem_ctrl_be_ram #(
        .AW(AW)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR_ON_RST ? CLEAR : READY;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == AW'(DEPTH - 1)) begin
                state <= READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        m_ld  <= !req_we && !err;
        m_err <= err;
        m_f3  <= req_funct3;
        m_off <= off;
    end

    // Stage 0 is formed from the RAM output; later stages are pure delay.
    always_comb begin
        v_in[0] = m_v;
        p_in[0] = {m_err, 32'h0};
        if (m_ld) begin
            p_in[0][31:0] = load_extract(ram_q, m_f3, m_off);
        end
        for (int i = 1; i < RD_LAT; i++) begin
            v_in[i] = pv[i-1];
            p_in[i] = pd[i-1];
        end
    end

    // Payload only advances with a valid beat so the last stage holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_v <= 1'b0;
            pv  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pd[i] <= '0;
            end
        end else begin
            m_v <= acc;
            pv  <= v_in;
            for (int i = 0; i < RD_LAT; i++) begin
                if (v_in[i]) begin
                    pd[i] <= p_in[i];
                end
            end
        end
    end

    assign rsp_valid = pv[RD_LAT-1];
    assign rsp_rdata = pd[RD_LAT-1][31:0];
    assign rsp_err   = pd[RD_LAT-1][32];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (clearing/RD_LAT=1, no clear/RD_LAT=3)
// share stimulus and are checked every cycle against a byte-level model.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rdy_a, rv_a, re_a;
    logic [31:0] rd_a;
    logic        rdy_b, rv_b, re_b;
    logic [31:0] rd_b;

    dmem_ctrl #(.AW(4), .RD_LAT(1), .CLEAR_ON_RST(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_ready(rdy_a), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(re_a)
    );

    dmem_ctrl #(.AW(4), .RD_LAT(3), .CLEAR_ON_RST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_ready(rdy_b), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(re_b)
    );

    typedef struct {
        int          due;
        logic [32:0] r;
        bit          lit_en;
        logic [32:0] lit;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [7:0]  mb [2][64];
    int          lat [2] = '{1, 3};
    bit          st_rdy [2];
    int          clr [2];
    logic [32:0] last [2];
    bit          lit_en [2];
    logic [32:0] lit [2];
    int          cyc = 0;
    bit          started = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [32:0] act,
                       input logic [32:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // Byte-level model of one accepted request.
    task automatic model(input int k, output exp_t x);
        int          a;
        int          sz;
        bit          legal;
        logic [31:0] v;
        a  = int'(req_addr);
        sz = (req_funct3[1:0] == 2'd0) ? 1 :
             (req_funct3[1:0] == 2'd1) ? 2 : 4;
        legal = req_we ? (req_funct3 <= 3'd2)
                       : (req_funct3 != 3'd3 && req_funct3 <= 3'd5);
        x.due    = cyc + lat[k];
        x.r      = {1'b1, 32'h0};
        x.lit_en = lit_en[k];
        x.lit    = lit[k];
        if (legal && (a % sz) == 0) begin
            x.r = 33'h0;
            if (req_we) begin
                for (int i = 0; i < sz; i++)
                    mb[k][a+i] = req_wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < sz; i++)
                    v[8*i +: 8] = mb[k][a+i];
                if (!req_funct3[2] && sz < 4 && v[8*sz-1])
                    for (int i = 8 * sz; i < 32; i++) v[i] = 1'b1;
                x.r = {1'b0, v};
            end
        end
    endtask

    exp_t mx;
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                if (k == 0) qa.delete(); else qb.delete();
                st_rdy[k] = (k == 1);
                clr[k]    = 0;
                last[k]   = 33'h0;
            end else if (st_rdy[k]) begin
                if (req_valid) begin
                    model(k, mx);
                    if (k == 0) qa.push_back(mx); else qb.push_back(mx);
                end
            end else begin
                for (int b = 0; b < 4; b++) mb[k][4*clr[k]+b] = 8'h00;
                clr[k]++;
                if (clr[k] == 16) st_rdy[k] = 1'b1;
            end
        end
        if (!rst_n) started = 1'b1;
    end

    exp_t        cx;
    bit          have;
    logic        cv;
    logic        crdy;
    logic [32:0] cgot;
    string       inst;
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                inst = (k == 0) ? "a" : "b";
                cv   = (k == 0) ? rv_a : rv_b;
                crdy = (k == 0) ? rdy_a : rdy_b;
                cgot = (k == 0) ? {re_a, rd_a} : {re_b, rd_b};
                have = 1'b0;
                if (k == 0) begin
                    if (qa.size() > 0 && qa[0].due == cyc) begin
                        cx = qa.pop_front(); have = 1'b1;
                    end
                end else begin
                    if (qb.size() > 0 && qb[0].due == cyc) begin
                        cx = qb.pop_front(); have = 1'b1;
                    end
                end
                chk({inst, "_req_ready"}, 33'(crdy),
                    33'(rst_n && st_rdy[k]));
                chk({inst, "_rsp_valid"}, 33'(cv), 33'(have));
                if (have) begin
                    chk({inst, "_rsp"}, cgot, cx.r);
                    last[k] = cx.r;
                    if (cx.lit_en) chk({inst, "_literal"}, cgot, cx.lit);
                end else begin
                    chk({inst, "_hold"}, cgot, last[k]);
                end
            end
        end
    end

    task automatic req(input logic we, input logic [2:0] f3,
                       input logic [5:0] a, input logic [31:0] wd,
                       input bit le, input logic [32:0] la,
                       input logic [32:0] lb);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        lit_en[0]  = le;
        lit_en[1]  = le;
        lit[0]     = la;
        lit[1]     = lb;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lit_en[0] = 1'b0;
        lit_en[1] = 1'b0;
    endtask

    task automatic st(input logic [2:0] f3, input logic [5:0] a,
                      input logic [31:0] wd);
        req(1'b1, f3, a, wd, 1'b0, 33'h0, 33'h0);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [5:0] a,
                      input logic [32:0] la, input logic [32:0] lb);
        req(1'b0, f3, a, 32'h0, 1'b1, la, lb);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!rdy_a && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    logic [31:0] pat [16];
    logic [31:0] x0;
    logic [2:0]  f3;
    logic [5:0]  ad;
    logic        we;
    int          n;
    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'h0; req_addr = 6'h0; req_wdata = 32'h0;
        lit_en[0] = 1'b0; lit_en[1] = 1'b0;
        lit[0] = 33'h0; lit[1] = 33'h0;
        idle(2);
        rst_n = 1'b1;

        // A is clearing: these stores land only in B.
        n = 0;
        for (int i = 0; i < 16; i++) begin
            pat[i] = $urandom;
            st(3'b010, 6'(4 * i), pat[i]);
            if (rdy_a && n == 0) n = i + 1;
        end
        chk("clear_edges", 33'(n), 33'd16);
        ld(3'b010, 6'h3C, 33'h0, {1'b0, pat[15]});

        st(3'b010, 6'h10, 32'h80FF7F01);
        ld(3'b000, 6'h11, 33'h0_0000007F, 33'h0_0000007F);
        ld(3'b000, 6'h13, 33'h0_FFFFFF80, 33'h0_FFFFFF80);
        ld(3'b100, 6'h13, 33'h0_00000080, 33'h0_00000080);
        ld(3'b101, 6'h12, 33'h0_000080FF, 33'h0_000080FF);
        ld(3'b001, 6'h12, 33'h0_FFFF80FF, 33'h0_FFFF80FF);

        st(3'b010, 6'h20, 32'hAABBCCDD);
        st(3'b000, 6'h21, 32'h00000011);
        st(3'b001, 6'h22, 32'h00002233);
        ld(3'b010, 6'h20, 33'h0_223311DD, 33'h0_223311DD);

        st(3'b010, 6'h04, 32'h12345678);
        ld(3'b010, 6'h06, 33'h1_00000000, 33'h1_00000000);
        req(1'b1, 3'b001, 6'h05, 32'hFFFF, 1'b1,
            33'h1_00000000, 33'h1_00000000);
        ld(3'b011, 6'h04, 33'h1_00000000, 33'h1_00000000);
        ld(3'b010, 6'h04, 33'h0_12345678, 33'h0_12345678);

        x0 = 32'h5A5AA5A5;
        st(3'b010, 6'h00, x0);
        repeat (4) ld(3'b010, 6'h00, {1'b0, x0}, {1'b0, x0});
        idle(4);

        // Two loads in flight, then a store on the reset edge.
        ld(3'b010, 6'h10, 33'h0_80FF7F01, 33'h0_80FF7F01);
        ld(3'b010, 6'h20, 33'h0_223311DD, 33'h0_223311DD);
        rst_n = 1'b0;
        st(3'b010, 6'h00, 32'hDEADBEEF);
        rst_n = 1'b1;
        idle(5);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        wait_ready(n);
        chk("reclear_edges", 33'(n), 33'd16);
        ld(3'b010, 6'h00, 33'h0, {1'b0, x0});
        ld(3'b010, 6'h20, 33'h0, 33'h0_223311DD);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end else if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                we = 1'($urandom);
                f3 = 3'($urandom);
                ad = 6'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    f3 = we ? 3'($urandom_range(0, 2))
                            : 3'($urandom_range(0, 2)) |
                              (3'($urandom_range(0, 1)) << 2);
                    if (f3 == 3'b110) f3 = 3'b100;
                end
                if ($urandom_range(0, 3) != 0) begin
                    if (f3[1:0] == 2'd1) ad[0] = 1'b0;
                    if (f3[1:0] == 2'd2) ad[1:0] = 2'd0;
                end
                req(we, f3, ad, $urandom, 1'b0, 33'h0, 33'h0);
            end
        end
        rst_n = 1'b1;
        idle(6);
        chk("drain", 33'(qa.size() + qb.size()), 33'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data memory for the single-cycle RISC-V datapath: a 32-bit word-organised synchronous RAM that takes byte-addressed load/store requests (RV32I funct3 encoding) over a valid/ready handshake. It adds byte/half/word stores via byte-lane enables, sign/zero-extended loads, misalignment and illegal-size error reporting, and a configurable read pipeline. An optional zero-fill sequence runs after reset. It sits between the core's load/store unit and on-chip data storage.

## Interface
- AW, 10, word-address bits; depth DEPTH = 2^AW words of 32 bits
- RD_LAT, 1, request-to-response latency in cycles, legal range 1..4
- CLEAR_ON_RST, 1, when 1 the block zero-fills all words after reset before accepting requests
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  access size/sign, RV32I encoding
- req_addr  in  AW+2  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response valid for exactly one cycle
- rsp_rdata  out  32  load result, extended to 32 bits
- rsp_err  out  1  request was misaligned or illegal

## Operation
- Reset: one clock with rst_n low. Effects:
  - state <= CLEAR if CLEAR_ON_RST=1, otherwise READY
  - clr_cnt <= 0
  - all pipeline valid bits <= 0
  - rsp_valid, rsp_rdata and rsp_err <= 0
  - req_ready = 0 while rst_n is low
- Memory contents are not altered by reset itself.
- State machine:
  - CLEAR: each edge writes 0 to mem[clr_cnt] and increments clr_cnt. At clr_cnt == DEPTH-1, state moves to READY.
  - READY: terminal state. req_ready = (state == READY) && rst_n.
- Accept: req_valid && req_ready at a rising edge. One request per cycle; no backpressure on the response side.
- Word index is req_addr[AW+1:2]. Lane offset is req_addr[1:0].
- Legal load funct3 codes: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store funct3 codes: 000 SB, 001 SH, 010 SW.
- Any other code is illegal.
- Misaligned accesses:
  - half access with addr[0] = 1
  - word access with addr[1:0] != 0
- Error requests (illegal or misaligned): no memory write; response carries rsp_err = 1 and rsp_rdata = 0.
- Store:
  - Byte lanes written on the accept edge.
  - SB writes lane off using wdata[7:0].
  - SH writes lanes off and off+1 using wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes keep their value.
  - The store response has rsp_rdata = 0.
- Load:
  - Word read at the accept edge.
  - Field selected by the lane offset.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- A load accepted the cycle after a store to the same word returns the stored data.

## Timing
- Response latency: rsp_valid rises RD_LAT edges after the accept edge. With RD_LAT=1, the response appears in the cycle following acceptance.
- Throughput: 1 request per cycle. Responses are returned in request order, each with rsp_valid high for one cycle.
- rsp_rdata and rsp_err hold their last value while rsp_valid = 0.
- CLEAR duration: req_ready first reads 1 after exactly DEPTH rising edges with rst_n high. With CLEAR_ON_RST=0, req_ready is 1 in the first cycle after reset is released.
- Requests presented during CLEAR are ignored (no write, no response).
- Reset mid-operation:
  - In-flight responses are dropped.
  - rsp_valid is 0 from the reset edge onward.
  - A store presented on the reset edge does not write.
  - Reset during CLEAR restarts clr_cnt at 0.
- Address wrap: none. The full byte address space maps to storage.

## Structure
- Package dmem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding (CLEAR, READY)
  - function be_mask(funct3, off), returning 4-bit lane enables
  - function load_extract(word, funct3, off), returning 32 bits
- Sub-module be_ram: DEPTH×32 storage with 4 byte write enables and registered read. dmem_ctrl holds the FSM, error checks, store lane alignment and the RD_LAT pipeline.

## Test plan
- Clear and ready (CLEAR_ON_RST=1, AW=4): release reset -> req_ready stays 0 for 16 edges, then 1; LW 0x3C -> rsp_rdata 0x00000000.
- Word store, byte and half loads: SW 0x10 ← 0x80FF7F01; then LB 0x11 -> 0x0000007F; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LHU 0x12 -> 0x000080FF; LH 0x12 -> 0xFFFF80FF.
- Partial store merge: SW 0x20 ← 0xAABBCCDD, SB 0x21 ← 0x11, SH 0x22 ← 0x2233 -> LW 0x20 returns 0x223311DD.
- Errors: LW 0x06, SH 0x05, funct3 011 -> each gets rsp_err = 1 and rsp_rdata = 0; memory unchanged, checked by LW 0x04.
- Latency and throughput (RD_LAT=3): back-to-back SW 0x0 then loads on 4 consecutive cycles -> rsp_valid exactly 3 edges after each accept, in order, with the load right after the store returning the new data.
- Reset mid-flight: two loads in flight with RD_LAT=3, rst_n low for one edge -> no rsp_valid afterwards; memory contents kept when CLEAR_ON_RST=0.
